display_arbiter: RTL and testbench
==================================

Name: display_arbiter

Overview:
- Shares the single 4-digit seven-segment display path between up to four requesters (CPU register tap, switch echo, debug counter, error code).
- Picks one requester at a time with round-robin arbitration and holds it for a minimum dwell time.
- Drives the 16-bit `binary` value consumed by the existing 4-digit 7-seg multiplexer, plus grant/status handshake signals back to the requesters.

Parameters:
- HOLD_CYCLES, 100000000, minimum dwell per grant in clk cycles (1 s at 100 MHz); legal range ≥ 2.
- CNT_W, 27, width of the dwell counter; must hold HOLD_CYCLES-1.

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  asynchronous, active-high reset.
- req  input  4  per-requester level request; bit i is requester i.
- req_data  input  64  requester values; requester i on bits [16i+15:16i].
- grant  output  4  one-hot current owner; all-zero when idle.
- owner  output  2  encoded index of current owner; holds the last owner when idle.
- active  output  1  high while any grant is held.
- done  output  1  single-cycle pulse on every release (switch or return to idle).
- binary  output  16  value to the 7-seg driver.

Behaviour:
- Reset (asynchronous, immediate, no clock edge needed):
  - grant=0, owner=0, active=0, done=0, binary=16'h0000, counter=0, state=IDLE.
  - Round-robin pointer = 3, so requester 0 has first priority.
- All outputs are registered. done defaults to 0 each cycle.
- Arbitration function: search starts at (pointer+1) mod 4, wraps, and returns the first set bit of the candidate mask. The pointer is updated to the winner on every grant.
- IDLE:
  - If req≠0, at the next edge: grant=onehot(winner), owner=winner, binary=req_data[winner], active=1, counter=0, state=HOLD.
  - Otherwise all outputs hold; binary keeps the last displayed value.
- HOLD, evaluated each edge, in priority order:
  1. Owner dropped (req[owner]=0):
     - Arbitrate among the remaining requests.
     - Winner exists: switch to it this edge, binary=req_data[winner], counter=0, done=1.
     - No winner: state=IDLE, grant=0, active=0, binary held, done=1.
  2. Dwell expired (counter==HOLD_CYCLES-1):
     - Arbitrate with the owner's bit masked out.
     - Winner exists: switch as above, done=1.
     - No winner: owner keeps the grant, counter=0, done=0.
  3. Otherwise: counter+1, binary=req_data[owner].
- binary tracks the owner's data live with 1-cycle latency.
- Dwell cannot be extended by a competitor arriving mid-hold; the competitor waits until expiry.
- No two grant bits are ever high simultaneously.
- A new request arriving on the same edge as a release takes part in that release's arbitration.
- Counter wraps only through an explicit reset to 0; it never exceeds HOLD_CYCLES-1.
- Reset asserted mid-HOLD returns immediately to reset values; the pointer also resets.

Test Plan (HOLD_CYCLES=8):
- Reset, then req=4'b0001, data0=16'h1234 → one edge later: grant=0001, owner=0, active=1, binary=16'h1234, done=0.
- req=4'b0011 held constant → grant=0001 for 8 cycles, then 0010 for 8, then 0001 again; done pulses exactly one cycle at each switch; binary alternates between data0 and data1.
- req=4'b0100 only, data2 changes 16'hAAAA→16'h5555 mid-hold → grant stays 0100 indefinitely, done never pulses, binary=16'h5555 one cycle after the change.
- Owner 0 drops req at hold cycle 3:
  - with req1 pending → grant=0010 on the next edge, done=1.
  - with nothing pending → grant=0, active=0, binary held at data0, done=1.
- req=4'b1111 from reset → grant order 0,1,2,3,0, each held 8 cycles.
- Assert reset asynchronously mid-hold (between edges) → grant, active, binary, done go to 0 without a clock edge; after release, req=4'b1010 → grant=0010 first.

Source files
------------

// File: rtl/display_arbiter.sv
// Round-robin owner selection for the shared 4-digit seven-segment display path.
// Each grant is kept for a minimum dwell time; every grant/status output comes straight from a flop.
module display_arbiter #(
   parameter int HOLD_CYCLES = 100000000,
   parameter int CNT_W       = 27
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [63:0] req_data,
   output logic [3:0]  grant,
   output logic [1:0]  owner,
   output logic        active,
   output logic        done,
   output logic [15:0] binary
);

   typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(HOLD_CYCLES - 1);

   state_t            r_state;
   logic [1:0]        r_ptr;
   logic [CNT_W-1:0]  r_cnt;
   logic [3:0]        r_grant;
   logic [1:0]        r_owner;
   logic              r_active;
   logic              r_done;
   logic [15:0]       r_binary;

   logic [2:0]        w_arb_all;
   logic [2:0]        w_arb_oth;
   logic [3:0]        w_owner_mask;

   // Returns {found, index}; the search starts after i_ptr and wraps, so i_ptr itself is tried last.
   function automatic logic [2:0] arb(input logic [3:0] i_mask, input logic [1:0] i_ptr);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 4; i >= 1; i--) begin
         idx = i_ptr + 2'(i);
         if (i_mask[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   function automatic logic [15:0] lane(input logic [63:0] i_data, input logic [1:0] i_idx);
      logic [15:0] res;
      case (i_idx)
         2'd0:    res = i_data[15:0];
         2'd1:    res = i_data[31:16];
         2'd2:    res = i_data[47:32];
         2'd3:    res = i_data[63:48];
         default: res = 16'h0000;
      endcase
      return res;
   endfunction

   assign w_owner_mask = 4'b0001 << r_owner;
   assign w_arb_all    = arb(req, r_ptr);
   // The owner's bit is masked out; this also covers the case where the owner has dropped its request.
   assign w_arb_oth    = arb(req & ~w_owner_mask, r_ptr);

   // Arbitration FSM: tracks the dwell time and registers every output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_ptr    <= 2'd3;
         r_cnt    <= '0;
         r_grant  <= 4'b0000;
         r_owner  <= 2'd0;
         r_active <= 1'b0;
         r_done   <= 1'b0;
         r_binary <= 16'h0000;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_arb_all[2]) begin
                  r_state  <= S_HOLD;
                  r_grant  <= 4'b0001 << w_arb_all[1:0];
                  r_owner  <= w_arb_all[1:0];
                  r_ptr    <= w_arb_all[1:0];
                  r_binary <= lane(req_data, w_arb_all[1:0]);
                  r_active <= 1'b1;
                  r_cnt    <= '0;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_HOLD: begin
               if (!req[r_owner] || (r_cnt == LP_LAST)) begin
                  if (w_arb_oth[2]) begin
                     r_grant  <= 4'b0001 << w_arb_oth[1:0];
                     r_owner  <= w_arb_oth[1:0];
                     r_ptr    <= w_arb_oth[1:0];
                     r_binary <= lane(req_data, w_arb_oth[1:0]);
                     r_cnt    <= '0;
                     r_done   <= 1'b1;
                  end else if (!req[r_owner]) begin
                     r_state  <= S_IDLE;
                     r_grant  <= 4'b0000;
                     r_active <= 1'b0;
                     r_cnt    <= '0;
                     r_done   <= 1'b1;
                  end else begin
                     r_cnt    <= '0;
                     r_binary <= lane(req_data, r_owner);
                  end
               end else begin
                  r_cnt    <= r_cnt + 1'b1;
                  r_binary <= lane(req_data, r_owner);
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_grant  <= 4'b0000;
               r_active <= 1'b0;
            end
         endcase
      end
   end

   assign grant  = r_grant;
   assign owner  = r_owner;
   assign active = r_active;
   assign done   = r_done;
   assign binary = r_binary;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: table vectors, hand-written dwell/reset sequences,
// and random traffic compared against a behavioural reference model.
module tb_display_arbiter;

   localparam int HOLD = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req = 4'b0000;
   logic [63:0] req_data = 64'h0;
   logic [3:0]  grant;
   logic [1:0]  owner;
   logic        active;
   logic        done;
   logic [15:0] binary;

   int n_pass = 0;
   int n_total = 0;

   display_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(3)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data),
      .grant(grant), .owner(owner), .active(active), .done(done), .binary(binary)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  r;
      logic [63:0] d;
      logic [3:0]  g;
      logic [1:0]  o;
      logic        a;
      logic        dn;
      logic [15:0] b;
   } vec_t;

   vec_t tbl[9];

   // Reference model state: owner index (-1 when idle), last owner, pointer, cycles held so far.
   int          m_owner;
   int          m_last;
   int          m_ptr;
   int          m_held;
   logic [15:0] m_bin;
   logic        m_done;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic step(input logic [3:0] r, input logic [63:0] d);
      @(negedge clk);
      req = r;
      req_data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req = 4'b0000;
      req_data = 64'h0;
      @(negedge clk);
      reset = 1'b0;
      m_owner = -1; m_last = 0; m_ptr = 3; m_held = 0; m_bin = 16'h0000; m_done = 1'b0;
   endtask

   function automatic int pick(input logic [3:0] m, input int p);
      int c;
      for (int k = 1; k <= 4; k++) begin
         c = (p + k) % 4;
         if (m[c]) return c;
      end
      return -1;
   endfunction

   task automatic take(input int w, input logic [63:0] d, input logic dn);
      m_owner = w; m_last = w; m_ptr = w; m_held = 1;
      m_bin = d[16*w +: 16];
      m_done = dn;
   endtask

   task automatic model_step(input logic [3:0] r, input logic [63:0] d);
      int w;
      m_done = 1'b0;
      if (m_owner < 0) begin
         if (r != 4'b0000) take(pick(r, m_ptr), d, 1'b0);
      end else if (!r[m_owner]) begin
         w = pick(r, m_ptr);
         if (w >= 0) take(w, d, 1'b1);
         else begin m_owner = -1; m_done = 1'b1; end
      end else if (m_held == HOLD) begin
         w = pick(r & ~(4'b0001 << m_owner), m_ptr);
         if (w >= 0) take(w, d, 1'b1);
         else begin m_held = 1; m_bin = d[16*m_owner +: 16]; end
      end else begin
         m_held++;
         m_bin = d[16*m_owner +: 16];
      end
   endtask

   task automatic check_model(input string nm);
      logic [3:0] eg;
      eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      chk({nm, ".grant"}, 64'(grant), 64'(eg));
      chk({nm, ".owner"}, 64'(owner), 64'(m_last[1:0]));
      chk({nm, ".active"}, 64'(active), 64'(m_owner >= 0));
      chk({nm, ".done"}, 64'(done), 64'(m_done));
      chk({nm, ".binary"}, 64'(binary), 64'(m_bin));
   endtask

   initial begin
      logic [3:0]  rr;
      logic [63:0] rd;
      logic [3:0]  eg;

      tbl[0] = '{4'b0001, 64'h0000_0000_0000_1234, 4'b0001, 2'd0, 1'b1, 1'b0, 16'h1234};
      tbl[1] = '{4'b0011, 64'h0000_0000_BEEF_1234, 4'b0001, 2'd0, 1'b1, 1'b0, 16'h1234};
      tbl[2] = '{4'b0011, 64'h0000_0000_BEEF_1234, 4'b0001, 2'd0, 1'b1, 1'b0, 16'h1234};
      tbl[3] = '{4'b0010, 64'h0000_0000_BEEF_1234, 4'b0010, 2'd1, 1'b1, 1'b1, 16'hBEEF};
      tbl[4] = '{4'b0000, 64'h0000_0000_BEEF_1234, 4'b0000, 2'd1, 1'b0, 1'b1, 16'hBEEF};
      tbl[5] = '{4'b0000, 64'h0000_0000_BEEF_1234, 4'b0000, 2'd1, 1'b0, 1'b0, 16'hBEEF};
      tbl[6] = '{4'b0001, 64'h0000_0000_BEEF_4321, 4'b0001, 2'd0, 1'b1, 1'b0, 16'h4321};
      tbl[7] = '{4'b0001, 64'h0000_0000_BEEF_1111, 4'b0001, 2'd0, 1'b1, 1'b0, 16'h1111};
      tbl[8] = '{4'b0000, 64'h0000_0000_BEEF_1111, 4'b0000, 2'd0, 1'b0, 1'b1, 16'h1111};

      do_reset();
      #1;
      chk("reset.grant", 64'(grant), 64'h0);
      chk("reset.owner", 64'(owner), 64'h0);
      chk("reset.active", 64'(active), 64'h0);
      chk("reset.done", 64'(done), 64'h0);
      chk("reset.binary", 64'(binary), 64'h0);

      for (int i = 0; i < 9; i++) begin
         step(tbl[i].r, tbl[i].d);
         chk($sformatf("vec%0d.grant", i), 64'(grant), 64'(tbl[i].g));
         chk($sformatf("vec%0d.owner", i), 64'(owner), 64'(tbl[i].o));
         chk($sformatf("vec%0d.active", i), 64'(active), 64'(tbl[i].a));
         chk($sformatf("vec%0d.done", i), 64'(done), 64'(tbl[i].dn));
         chk($sformatf("vec%0d.binary", i), 64'(binary), 64'(tbl[i].b));
      end

      // Two requesters alternate every HOLD cycles, with a one-cycle done pulse at each switch.
      do_reset();
      for (int k = 1; k <= 3 * HOLD; k++) begin
         step(4'b0011, 64'h0000_0000_00B1_00A0);
         chk($sformatf("alt%0d.grant", k), 64'(grant), (((k - 1) / HOLD) % 2 == 1) ? 64'h2 : 64'h1);
         chk($sformatf("alt%0d.done", k), 64'(done), 64'((k > HOLD) && ((k - 1) % HOLD == 0)));
         chk($sformatf("alt%0d.binary", k), 64'(binary), (((k - 1) / HOLD) % 2 == 1) ? 64'hB1 : 64'hA0);
      end

      // All four requesting: rotation 0,1,2,3,0.
      do_reset();
      for (int k = 1; k <= 5 * HOLD; k++) begin
         step(4'b1111, 64'h4444_3333_2222_1111);
         eg = 4'b0001 << (((k - 1) / HOLD) % 4);
         chk($sformatf("rr%0d.grant", k), 64'(grant), 64'(eg));
      end

      // Single requester keeps the grant past expiry, with binary following its data live.
      do_reset();
      for (int k = 1; k <= 3 * HOLD; k++) begin
         step(4'b0100, (k >= 5) ? 64'h0000_5555_0000_0000 : 64'h0000_AAAA_0000_0000);
         chk($sformatf("solo%0d.grant", k), 64'(grant), 64'h4);
         chk($sformatf("solo%0d.done", k), 64'(done), 64'h0);
         chk($sformatf("solo%0d.binary", k), 64'(binary), (k >= 5) ? 64'h5555 : 64'hAAAA);
      end

      // Asynchronous reset between edges, then the pointer restarts so requester 1 wins over 3.
      do_reset();
      for (int k = 0; k < 4; k++) step(4'b0001, 64'h0000_0000_0000_7777);
      #2 reset = 1'b1;
      #1;
      chk("arst.grant", 64'(grant), 64'h0);
      chk("arst.active", 64'(active), 64'h0);
      chk("arst.binary", 64'(binary), 64'h0);
      chk("arst.done", 64'(done), 64'h0);
      @(negedge clk);
      reset = 1'b0;
      step(4'b1010, 64'h3333_0000_1111_0000);
      chk("arst.after.grant", 64'(grant), 64'h2);
      chk("arst.after.binary", 64'(binary), 64'h1111);

      // Random traffic against the reference model.
      do_reset();
      rr = 4'b0000;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 5) == 0) rr = rr ^ (4'b0001 << $urandom_range(0, 3));
         rd = {$urandom, $urandom};
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
            rr = 4'b0000;
         end else begin
            step(rr, rd);
            model_step(rr, rd);
            check_model($sformatf("rand%0d", k));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
